hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the single-cycle load-use Hazard_Detection_Unit.
- Tracks every in-flight load destination register with a per-register countdown, so loads of configurable latency are supported.
- Generates the ID-stage stall, honours immediate-mode operands and an optional hardwired zero register, and counts stall cycles for performance monitoring.
- Sits between the ID/EX pipeline register and the pipeline control logic.

Parameters:
- REG_ADDR_W, 4: register-specifier width.
- NUM_REGS, 16: number of architectural registers, equal to 2**REG_ADDR_W.
- LOAD_LAT, 1: cycles after issue before a load result is forwardable. Legal range 1..15.
- ZERO_REG_EN, 0: when 1, register 0 is never tracked and never causes a stall.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  instruction moving ID->EX this cycle.
- issue_mem_read  in  1  issuing instruction is a load.
- issue_reg_write  in  1  issuing instruction writes a register.
- issue_dst  in  REG_ADDR_W  destination of the issuing instruction.
- id_valid  in  1  valid instruction present in ID.
- id_immd  in  1  ID instruction's second operand is an immediate.
- id_src1  in  REG_ADDR_W  ID first source register.
- id_src2  in  REG_ADDR_W  ID second source register.
- flush  in  1  pipeline flush; kills the ID instruction.
- stall  out  1  hold PC/IF/ID and insert a bubble into EX.
- busy_mask  out  NUM_REGS  bit r set while register r has a pending load.
- stall_count  out  STALL_CNT_W  saturating count of stalled cycles.

Behaviour:
- State: one countdown cnt[r] per register, width CNT_W = $clog2(LOAD_LAT+1), minimum 1.
- Reset: rst_n low asynchronously clears all cnt to 0 and stall_count to 0, so busy_mask = 0 and stall = 0. Reset mid-countdown discards all pending entries.
- busy_mask[r] = (cnt[r] != 0). The output is registered-state derived and combinational from cnt only.
- stall, combinational: id_valid & !flush & (busy[id_src1] | (!id_immd & busy[id_src2])).
  - With ZERO_REG_EN = 1, a source of 0 never matches.
- Effective issue: eff_issue = issue_valid & !stall & !flush. When stall is high, the controller's issue_valid is ignored because a bubble enters EX.
- Load allocate: on eff_issue & issue_mem_read & issue_reg_write, and dst != 0 when ZERO_REG_EN = 1, cnt[issue_dst] <= LOAD_LAT on the next clk edge.
- Decrement: every other nonzero cnt[r] decrements by 1 each cycle and stops at 0.
- Same-register collision: when an allocate and a decrement hit the same register in one cycle, the allocate wins and cnt is reloaded to LOAD_LAT.
- Non-load writes: an issue with issue_reg_write = 1 and issue_mem_read = 0 to a busy register clears cnt[issue_dst] to 0. The younger ALU result is forwarded normally, so no WAW stall is needed.
- Latency: a load issued at edge N makes dependents in ID stall for exactly LOAD_LAT cycles (edges N+1..N+LOAD_LAT). The stall drops in the cycle after cnt reaches 0.
- LOAD_LAT = 1 reproduces the legacy single-bubble load-use behaviour.
- Flush: forces stall = 0 and suppresses allocation. Pending counters keep decrementing, because older loads already past ID still complete.
- stall_count: increments on each clk edge where stall = 1 and saturates at all-ones; it does not wrap.

Decomposition:
- Shared package/header: REG_ADDR_W and NUM_REGS defaults, the LOAD_LAT range check, and the CNT_W derivation macro.
- One natural sub-module, hazard_reg_counter: a single register's countdown with load, clear, and decrement-to-zero.
  - Instantiated NUM_REGS times in a generate loop.
  - Top level holds the decode, stall logic and stall counter.

Test Plan:
- Reset then idle with id_src1 = 5 and id_valid = 1 -> stall = 0, busy_mask = 0, stall_count = 0.
- LOAD_LAT = 1: load to r5 issued, then ID src1 = 5 -> stall = 1 for exactly 1 cycle; busy_mask = 0x0020 then 0; stall_count = 1.
- LOAD_LAT = 3: load to r5, then ID src2 = 5 with id_immd = 1 -> no stall. Same with id_immd = 0 -> stall high for 3 cycles; stall_count = 3.
- LOAD_LAT = 2: load r7, then issue load r7 again while cnt[r7] = 1 -> cnt reloaded to 2, busy[7] stays high 2 more cycles. An ALU write to r7 instead clears busy[7] the next cycle.
- ZERO_REG_EN = 1: load to r0, then ID src1 = 0 -> no stall, busy_mask stays 0. Flush asserted during a stall -> stall = 0 that cycle and no allocation from issue_valid.
- Assert rst_n low mid-countdown with busy_mask = 0x0020 -> busy_mask = 0 and stall = 0 immediately, without waiting for clk. Force 2**STALL_CNT_W + 5 stall cycles with a small STALL_CNT_W -> stall_count holds all-ones.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and helpers for the load-latency hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int DEF_REG_ADDR_W = 4;
  localparam int DEF_NUM_REGS   = 2 ** DEF_REG_ADDR_W;
  localparam int MIN_LOAD_LAT   = 1;
  localparam int MAX_LOAD_LAT   = 15;

  // True when a load latency lies in the supported range.
  function automatic bit load_lat_ok(input int lat);
    return (lat >= MIN_LOAD_LAT) && (lat <= MAX_LOAD_LAT);
  endfunction

  // Countdown width able to hold LOAD_LAT, never narrower than one bit.
  function automatic int cnt_w(input int lat);
    int w;
    w = $clog2(lat + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/hazard_reg_counter.sv
// One register's pending-load countdown: reload, clear, decrement to zero.
module hazard_reg_counter
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W    = 1,
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_clear,
  output logic o_busy
);

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_VAL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Reload wins over clear and decrement; otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_CNT;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Multi-cycle load-use scoreboard: per-register countdowns, ID stall, stall counter.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_ADDR_W  = DEF_REG_ADDR_W,
  parameter int NUM_REGS    = DEF_NUM_REGS,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_REG_EN = 0,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  input  logic                   issue_mem_read,
  input  logic                   issue_reg_write,
  input  logic [REG_ADDR_W-1:0]  issue_dst,
  input  logic                   id_valid,
  input  logic                   id_immd,
  input  logic [REG_ADDR_W-1:0]  id_src1,
  input  logic [REG_ADDR_W-1:0]  id_src2,
  input  logic                   flush,
  output logic                   stall,
  output logic [NUM_REGS-1:0]    busy_mask,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int CNT_W = cnt_w(LOAD_LAT);
  localparam logic [STALL_CNT_W-1:0] STALL_ONE = STALL_CNT_W'(1);

  if (!load_lat_ok(LOAD_LAT)) begin : g_bad_lat
    $error("hazard_scoreboard: LOAD_LAT out of range 1..15");
  end
  if (NUM_REGS != (2 ** REG_ADDR_W)) begin : g_bad_regs
    $error("hazard_scoreboard: NUM_REGS must equal 2**REG_ADDR_W");
  end

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_REGS-1:0] w_load;
  logic [NUM_REGS-1:0] w_clear;
  logic                w_src1_hit;
  logic                w_src2_hit;
  logic                w_stall;
  logic                w_eff_issue;
  logic                w_dst_ok;
  logic [STALL_CNT_W-1:0] r_stall_count;

  // Source match against pending loads; register 0 is exempt when hardwired.
  always_comb begin
    w_src1_hit = w_busy[id_src1];
    w_src2_hit = w_busy[id_src2];
    if (ZERO_REG_EN != 0) begin
      if (id_src1 == '0) w_src1_hit = 1'b0;
      if (id_src2 == '0) w_src2_hit = 1'b0;
    end
    w_stall     = id_valid & ~flush & (w_src1_hit | (~id_immd & w_src2_hit));
    w_eff_issue = issue_valid & ~w_stall & ~flush;
    w_dst_ok    = !((ZERO_REG_EN != 0) && (issue_dst == '0));
  end

  // Per-register decode of the effective issue into reload / clear strobes.
  always_comb begin
    w_load  = '0;
    w_clear = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (w_eff_issue && issue_reg_write && (issue_dst == REG_ADDR_W'(r))) begin
        w_load[r]  = issue_mem_read & w_dst_ok;
        w_clear[r] = ~issue_mem_read;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    hazard_reg_counter #(
      .CNT_W    (CNT_W),
      .LOAD_VAL (LOAD_LAT)
    ) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[g]),
      .i_clear (w_clear[g]),
      .o_busy  (w_busy[g])
    );
  end

  // Saturating count of cycles spent stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + STALL_ONE;
    end
  end

  assign stall       = w_stall;
  assign busy_mask   = w_busy;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: several parameterisations share one stimulus bus.
module tb_hazard_scoreboard;

  logic       clk;
  logic       rst_n;
  logic       issue_valid, issue_mem_read, issue_reg_write;
  logic [3:0] issue_dst;
  logic       id_valid, id_immd, flush;
  logic [3:0] id_src1, id_src2;

  logic        stall_l1, stall_l2, stall_l3, stall_z, stall_s;
  logic [15:0] busy_l1, busy_l2, busy_l3, busy_z, busy_s;
  logic [15:0] cnt_l1, cnt_l2, cnt_l3, cnt_z;
  logic [2:0]  cnt_s;

  int tests_run;
  int tests_failed;

  hazard_scoreboard #(.LOAD_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_mem_read(issue_mem_read),
    .issue_reg_write(issue_reg_write), .issue_dst(issue_dst), .id_valid(id_valid),
    .id_immd(id_immd), .id_src1(id_src1), .id_src2(id_src2), .flush(flush),
    .stall(stall_l1), .busy_mask(busy_l1), .stall_count(cnt_l1));

  hazard_scoreboard #(.LOAD_LAT(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_mem_read(issue_mem_read),
    .issue_reg_write(issue_reg_write), .issue_dst(issue_dst), .id_valid(id_valid),
    .id_immd(id_immd), .id_src1(id_src1), .id_src2(id_src2), .flush(flush),
    .stall(stall_l2), .busy_mask(busy_l2), .stall_count(cnt_l2));

  hazard_scoreboard #(.LOAD_LAT(3)) dut_l3 (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_mem_read(issue_mem_read),
    .issue_reg_write(issue_reg_write), .issue_dst(issue_dst), .id_valid(id_valid),
    .id_immd(id_immd), .id_src1(id_src1), .id_src2(id_src2), .flush(flush),
    .stall(stall_l3), .busy_mask(busy_l3), .stall_count(cnt_l3));

  hazard_scoreboard #(.LOAD_LAT(2), .ZERO_REG_EN(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_mem_read(issue_mem_read),
    .issue_reg_write(issue_reg_write), .issue_dst(issue_dst), .id_valid(id_valid),
    .id_immd(id_immd), .id_src1(id_src1), .id_src2(id_src2), .flush(flush),
    .stall(stall_z), .busy_mask(busy_z), .stall_count(cnt_z));

  hazard_scoreboard #(.LOAD_LAT(15), .STALL_CNT_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_mem_read(issue_mem_read),
    .issue_reg_write(issue_reg_write), .issue_dst(issue_dst), .id_valid(id_valid),
    .id_immd(id_immd), .id_src1(id_src1), .id_src2(id_src2), .flush(flush),
    .stall(stall_s), .busy_mask(busy_s), .stall_count(cnt_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_issue(input logic v, input logic mr, input logic rw, input logic [3:0] d);
    issue_valid     = v;
    issue_mem_read  = mr;
    issue_reg_write = rw;
    issue_dst       = d;
  endtask

  task automatic drive_id(input logic v, input logic immd, input logic [3:0] s1,
                          input logic [3:0] s2, input logic fl);
    id_valid = v;
    id_immd  = immd;
    id_src1  = s1;
    id_src2  = s2;
    flush    = fl;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_issue(0, 0, 0, 4'd0);
    drive_id(0, 0, 4'd0, 4'd0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_issue(0, 0, 0, 4'd0);
    drive_id(1, 0, 4'd5, 4'd0, 0);
    #1;
    tests_run++;
    if (stall_l1 !== 1'b0) begin
      tests_failed++; $display("FAIL reset_stall: got %b expected 0", stall_l1);
    end
    tests_run++;
    if (busy_l1 !== 16'h0000) begin
      tests_failed++; $display("FAIL reset_busy: got %h expected 0000", busy_l1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); #1;
    tests_run++;
    if (stall_l1 !== 1'b0 || busy_l1 !== 16'h0000 || cnt_l1 !== 16'd0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: got stall=%b busy=%h cnt=%0d expected 0/0000/0",
               stall_l1, busy_l1, cnt_l1);
    end
  endtask

  task automatic test_lat1();
    do_reset();
    @(negedge clk); drive_issue(1, 1, 1, 4'd5); drive_id(0, 0, 4'd0, 4'd0, 0);
    @(negedge clk); drive_issue(0, 0, 0, 4'd0); drive_id(1, 0, 4'd5, 4'd0, 0); #1;
    tests_run++;
    if (stall_l1 !== 1'b1) begin
      tests_failed++; $display("FAIL lat1_stall: got %b expected 1", stall_l1);
    end
    tests_run++;
    if (busy_l1 !== 16'h0020) begin
      tests_failed++; $display("FAIL lat1_busy: got %h expected 0020", busy_l1);
    end
    @(negedge clk); #1;
    tests_run++;
    if (stall_l1 !== 1'b0 || busy_l1 !== 16'h0000) begin
      tests_failed++;
      $display("FAIL lat1_release: got stall=%b busy=%h expected 0/0000", stall_l1, busy_l1);
    end
    tests_run++;
    if (cnt_l1 !== 16'd1) begin
      tests_failed++; $display("FAIL lat1_count: got %0d expected 1", cnt_l1);
    end
  endtask

  task automatic test_lat3_immd();
    do_reset();
    @(negedge clk); drive_issue(1, 1, 1, 4'd5); drive_id(0, 0, 4'd0, 4'd0, 0);
    @(negedge clk); drive_issue(0, 0, 0, 4'd0); drive_id(1, 1, 4'd0, 4'd5, 0); #1;
    tests_run++;
    if (stall_l3 !== 1'b0 || busy_l3 !== 16'h0020) begin
      tests_failed++;
      $display("FAIL lat3_immd: got stall=%b busy=%h expected 0/0020", stall_l3, busy_l3);
    end
    do_reset();
    @(negedge clk); drive_issue(1, 1, 1, 4'd5); drive_id(0, 0, 4'd0, 4'd0, 0);
    @(negedge clk); drive_issue(0, 0, 0, 4'd0);
    drive_id(1, 0, 4'd0, 4'd5, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (stall_l3 !== 1'b1) begin
        tests_failed++; $display("FAIL lat3_stall_c%0d: got %b expected 1", i, stall_l3);
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (stall_l3 !== 1'b0) begin
      tests_failed++; $display("FAIL lat3_release: got %b expected 0", stall_l3);
    end
    tests_run++;
    if (cnt_l3 !== 16'd3) begin
      tests_failed++; $display("FAIL lat3_count: got %0d expected 3", cnt_l3);
    end
  endtask

  task automatic test_lat2_reload();
    logic exp_busy [4];
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    @(negedge clk); drive_issue(1, 1, 1, 4'd7); drive_id(0, 0, 4'd0, 4'd0, 0);
    @(negedge clk); drive_issue(0, 0, 0, 4'd0);
    @(negedge clk); drive_issue(1, 1, 1, 4'd7);
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if (busy_l2[7] !== exp_busy[i]) begin
        tests_failed++;
        $display("FAIL lat2_reload_c%0d: got %b expected %b", i, busy_l2[7], exp_busy[i]);
      end
      @(negedge clk);
      drive_issue(0, 0, 0, 4'd0);
    end
    do_reset();
    @(negedge clk); drive_issue(1, 1, 1, 4'd7);
    @(negedge clk); drive_issue(1, 0, 1, 4'd7); #1;
    tests_run++;
    if (busy_l2 !== 16'h0080) begin
      tests_failed++; $display("FAIL alu_pre: got %h expected 0080", busy_l2);
    end
    @(negedge clk); drive_issue(0, 0, 0, 4'd0); #1;
    tests_run++;
    if (busy_l2 !== 16'h0000) begin
      tests_failed++; $display("FAIL alu_clear: got %h expected 0000", busy_l2);
    end
  endtask

  task automatic test_zero_and_flush();
    do_reset();
    @(negedge clk); drive_issue(1, 1, 1, 4'd0); drive_id(0, 0, 4'd0, 4'd0, 0);
    @(negedge clk); drive_issue(0, 0, 0, 4'd0); drive_id(1, 0, 4'd0, 4'd0, 0); #1;
    tests_run++;
    if (stall_z !== 1'b0 || busy_z !== 16'h0000) begin
      tests_failed++;
      $display("FAIL zero_reg: got stall=%b busy=%h expected 0/0000", stall_z, busy_z);
    end
    do_reset();
    @(negedge clk); drive_issue(1, 1, 1, 4'd5); drive_id(0, 0, 4'd0, 4'd0, 0);
    @(negedge clk); drive_issue(0, 0, 0, 4'd0); drive_id(1, 0, 4'd5, 4'd0, 0); #1;
    tests_run++;
    if (stall_z !== 1'b1) begin
      tests_failed++; $display("FAIL flush_pre_stall: got %b expected 1", stall_z);
    end
    @(negedge clk); drive_issue(1, 1, 1, 4'd9); drive_id(1, 0, 4'd5, 4'd0, 1); #1;
    tests_run++;
    if (stall_z !== 1'b0 || busy_z !== 16'h0020) begin
      tests_failed++;
      $display("FAIL flush_stall: got stall=%b busy=%h expected 0/0020", stall_z, busy_z);
    end
    @(negedge clk); drive_issue(0, 0, 0, 4'd0); drive_id(0, 0, 4'd0, 4'd0, 0); #1;
    tests_run++;
    if (busy_z !== 16'h0000) begin
      tests_failed++; $display("FAIL flush_no_alloc: got %h expected 0000", busy_z);
    end
    tests_run++;
    if (cnt_z !== 16'd1) begin
      tests_failed++; $display("FAIL flush_count: got %0d expected 1", cnt_z);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk); drive_issue(1, 1, 1, 4'd5); drive_id(0, 0, 4'd0, 4'd0, 0);
    @(negedge clk); drive_issue(0, 0, 0, 4'd0); drive_id(1, 0, 4'd5, 4'd0, 0); #1;
    tests_run++;
    if (busy_l3 !== 16'h0020) begin
      tests_failed++; $display("FAIL async_pre: got %h expected 0020", busy_l3);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy_l3 !== 16'h0000 || stall_l3 !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: got busy=%h stall=%b expected 0000/0", busy_l3, stall_l3);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk); drive_issue(1, 1, 1, 4'd5); drive_id(0, 0, 4'd0, 4'd0, 0);
    @(negedge clk); drive_issue(0, 0, 0, 4'd0); drive_id(1, 0, 4'd5, 4'd0, 0);
    for (int i = 0; i < 13; i++) begin
      #1;
      if (i == 6) begin
        tests_run++;
        if (cnt_s !== 3'd6) begin
          tests_failed++; $display("FAIL sat_mid: got %0d expected 6", cnt_s);
        end
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (cnt_s !== 3'd7) begin
      tests_failed++; $display("FAIL sat_hold: got %0d expected 7", cnt_s);
    end
    tests_run++;
    if (stall_s !== 1'b1) begin
      tests_failed++; $display("FAIL sat_still_stalled: got %b expected 1", stall_s);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    drive_issue(0, 0, 0, 4'd0);
    drive_id(0, 0, 4'd0, 4'd0, 0);
    test_reset();
    test_lat1();
    test_lat3_immd();
    test_lat2_reload();
    test_zero_and_flush();
    test_async_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
